// File: rtl/rv32i_instr_encoder_if.sv
// Request and instruction-memory write bus of the RV32I instruction encoder.
// The master side issues instruction fields and plays the memory.
// The slave side is the encoder itself.
interface rv32i_instr_encoder_if;
    // request side
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm;
    // instruction-memory write side
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    // status
    logic        done;
    logic        err;
    logic [7:0]  err_count;

    modport master (
        output in_valid, fmt, opcode, rd, funct3, rs1, rs2, funct7, imm, wr_ready,
        input  in_ready, wr_valid, wr_addr, wr_data, done, err, err_count
    );

    modport slave (
        input  in_valid, fmt, opcode, rd, funct3, rs1, rs2, funct7, imm, wr_ready,
        output in_ready, wr_valid, wr_addr, wr_data, done, err, err_count
    );
endinterface

// File: rtl/rv32i_instr_encoder.sv
// RV32I instruction encoder / program loader.
// Assembles a 32-bit instruction word from its fields and a format tag, and
// streams each legal word to instruction memory at sequential word addresses.
// A single output register holds the word in flight. It can be refilled in
// the same cycle that it drains, which gives one word per clock.
module rv32i_instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned DEPTH     = 64
) (
    input  logic                  clk,
    input  logic                  reset,   // synchronous, active low
    input  logic                  clear,   // synchronous restart, keeps err state
    rv32i_instr_encoder_if.slave  bus
);

    // Counters must hold DEPTH itself (up to 2^30).
    localparam int unsigned CW = 31;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    logic          wr_valid_q, wr_valid_d;
    logic [31:0]   wr_addr_q,  wr_addr_d;
    logic [31:0]   wr_data_q,  wr_data_d;
    logic [CW-1:0] issued_q,   issued_d;
    logic [CW-1:0] written_q,  written_d;
    logic          done_q,     done_d;
    logic          err_q,      err_d;
    logic [7:0]    err_cnt_q,  err_cnt_d;

    logic [31:0] enc;
    logic        legal;
    logic        in_ready;
    logic        accept;
    logic        load;
    logic        drain;

    // Field placement for each format; this mirrors what the decoder extracts.
    always_comb begin
        enc = 32'h0;
        unique case (bus.fmt)
            FMT_R: enc = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
            FMT_I: enc = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
            FMT_S: enc = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3,
                          bus.imm[4:0], bus.opcode};
            FMT_B: enc = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                          bus.imm[4:1], bus.imm[11], bus.opcode};
            FMT_U: enc = {bus.imm[31:12], bus.rd, bus.opcode};
            FMT_J: enc = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12],
                          bus.rd, bus.opcode};
            default: enc = 32'h0;
        endcase
    end

    // Legality: a known format, a 32-bit opcode space (low bits 11), and an
    // immediate that survives the truncation its format applies.
    // A sign-extended field shows up as all-equal upper bits.
    always_comb begin
        legal = (bus.opcode[1:0] == 2'b11);
        unique case (bus.fmt)
            FMT_R: legal = legal;
            FMT_I,
            FMT_S: legal = legal && ((&bus.imm[31:11]) || !(|bus.imm[31:11]));
            FMT_B: legal = legal && !bus.imm[0] &&
                           ((&bus.imm[31:12]) || !(|bus.imm[31:12]));
            FMT_U: legal = legal && (bus.imm[11:0] == 12'h0);
            FMT_J: legal = legal && !bus.imm[0] &&
                           ((&bus.imm[31:20]) || !(|bus.imm[31:20]));
            default: legal = 1'b0;
        endcase
    end

    // Handshakes. The request side is ready whenever the output register is
    // empty or is emptying this cycle, and words remain to be issued.
    assign in_ready = reset && !clear && (issued_q < DEPTH_C) &&
                      (!wr_valid_q || bus.wr_ready);
    assign accept   = bus.in_valid && in_ready;
    assign load     = accept && legal;
    assign drain    = wr_valid_q && bus.wr_ready;

    // Next state: drain the current word, then optionally load a fresh one.
    always_comb begin
        wr_valid_d = wr_valid_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        issued_d   = issued_q;
        written_d  = written_q;
        done_d     = done_q;
        err_d      = err_q;
        err_cnt_d  = err_cnt_q;

        if (drain) begin
            wr_valid_d = 1'b0;
            wr_addr_d  = wr_addr_q + 32'd4;   // natural 32-bit wrap
            written_d  = written_q + 1'b1;
            if (written_q + 1'b1 == DEPTH_C)
                done_d = 1'b1;
        end

        if (load) begin
            wr_valid_d = 1'b1;
            wr_data_d  = enc;
            issued_d   = issued_q + 1'b1;
        end

        // Illegal requests are consumed silently apart from the error record.
        if (accept && !legal) begin
            err_d     = 1'b1;
            err_cnt_d = (err_cnt_q == 8'hFF) ? 8'hFF : err_cnt_q + 8'd1;
        end
    end

    // State register: reset clears everything, clear keeps the error record.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_valid_q <= 1'b0;
            wr_addr_q  <= BASE_ADDR;
            wr_data_q  <= 32'h0;
            issued_q   <= '0;
            written_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= 8'h0;
        end else if (clear) begin
            wr_valid_q <= 1'b0;
            wr_addr_q  <= BASE_ADDR;
            wr_data_q  <= 32'h0;
            issued_q   <= '0;
            written_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            issued_q   <= issued_d;
            written_q  <= written_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.wr_valid  = wr_valid_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.err_count = err_cnt_q;

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// Bench for rv32i_instr_encoder.
// Instance A (base 0, 64 words) runs the directed encodings and then a
// randomized run, checked every cycle against a reference model.
// Instance B (base 0xFFFFFFFC, 2 words) covers wrap, done, clear and reset
// during a stalled write.
module tb_rv32i_instr_encoder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, clr_a, clr_b, va, vb, ra, rb;
    logic [2:0]  fmt;
    logic [6:0]  opc;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        mon_on = 1'b0;
    logic        rnd_rdy = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    rv32i_instr_encoder_if ifa ();
    rv32i_instr_encoder_if ifb ();

    assign ifa.in_valid = va;  assign ifb.in_valid = vb;
    assign ifa.wr_ready = ra;  assign ifb.wr_ready = rb;
    assign ifa.fmt = fmt;      assign ifb.fmt = fmt;
    assign ifa.opcode = opc;   assign ifb.opcode = opc;
    assign ifa.rd = rd;        assign ifb.rd = rd;
    assign ifa.funct3 = f3;    assign ifb.funct3 = f3;
    assign ifa.rs1 = rs1;      assign ifb.rs1 = rs1;
    assign ifa.rs2 = rs2;      assign ifb.rs2 = rs2;
    assign ifa.funct7 = f7;    assign ifb.funct7 = f7;
    assign ifa.imm = imm;      assign ifb.imm = imm;

    rv32i_instr_encoder #(.BASE_ADDR(32'h0), .DEPTH(64)) dut_a (
        .clk(clk), .reset(rst_a), .clear(clr_a), .bus(ifa.slave));
    rv32i_instr_encoder #(.BASE_ADDR(32'hFFFF_FFFC), .DEPTH(2)) dut_b (
        .clk(clk), .reset(rst_b), .clear(clr_b), .bus(ifb.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference encoder built from the value ranges each format can carry.
    function automatic void ref_enc(input logic [2:0] f, input logic [6:0] o,
                                    input logic [4:0] d, input logic [2:0] fn3,
                                    input logic [4:0] s1, input logic [4:0] s2,
                                    input logic [6:0] fn7, input logic [31:0] im,
                                    output bit ok, output logic [31:0] w);
        int s;
        int unsigned u, base;
        s = $signed(im);
        u = im;
        base = (int'(s1) << 15) | (int'(fn3) << 12) | int'(o);
        ok = (o % 4 == 3);
        w = 32'h0;
        case (f)
            3'd0: w = (int'(fn7) << 25) | (int'(s2) << 20) | base | (int'(d) << 7);
            3'd1: begin
                ok = ok && s >= -2048 && s <= 2047;
                w = ((u % 4096) << 20) | base | (int'(d) << 7);
            end
            3'd2: begin
                ok = ok && s >= -2048 && s <= 2047;
                w = (((u / 32) % 128) << 25) | (int'(s2) << 20) | base | ((u % 32) << 7);
            end
            3'd3: begin
                ok = ok && (u % 2 == 0) && s >= -4096 && s <= 4095;
                w = (((u / 4096) % 2) << 31) | (((u / 32) % 64) << 25) |
                    (int'(s2) << 20) | base | (((u / 2) % 16) << 8) | (((u / 2048) % 2) << 7);
            end
            3'd4: begin
                ok = ok && (u % 4096 == 0);
                w = u | (int'(d) << 7) | int'(o);
            end
            3'd5: begin
                ok = ok && (u % 2 == 0) && s >= -1048576 && s <= 1048575;
                w = (((u / 1048576) % 2) << 31) | (((u / 2) % 1024) << 21) |
                    (((u / 2048) % 2) << 20) | (((u / 4096) % 256) << 12) |
                    (int'(d) << 7) | int'(o);
            end
            default: ok = 1'b0;
        endcase
    endfunction

    // Model of instance A: pending words, address, counters, error record.
    logic [31:0] q[$];
    logic [31:0] m_addr = 32'h0;
    int          m_issued = 0, m_written = 0, m_errc = 0;
    bit          m_err = 1'b0;

    // Compare every cycle, then advance the model for the coming edge.
    always @(negedge clk) begin
        if (mon_on) begin
            bit ok;
            bit exp_rdy;
            logic [31:0] w;
            exp_rdy = rst_a && !clr_a && m_issued < 64 && (q.size() == 0 || ra);
            chk("a.wr_valid", ifa.wr_valid, q.size() != 0);
            if (q.size() != 0) begin
                chk("a.wr_data", ifa.wr_data, q[0]);
                chk("a.wr_addr", ifa.wr_addr, m_addr);
            end
            chk("a.done", ifa.done, m_written == 64);
            chk("a.err", ifa.err, m_err);
            chk("a.err_count", ifa.err_count, m_errc);
            chk("a.in_ready", ifa.in_ready, exp_rdy);
            if (!rst_a || clr_a) begin
                q.delete();
                m_addr = 32'h0; m_issued = 0; m_written = 0;
                if (!rst_a) begin m_err = 1'b0; m_errc = 0; end
            end else begin
                if (q.size() != 0 && ra) begin
                    void'(q.pop_front());
                    m_addr += 32'd4;
                    m_written++;
                end
                if (va && exp_rdy) begin
                    ref_enc(fmt, opc, rd, f3, rs1, rs2, f7, imm, ok, w);
                    if (ok) begin q.push_back(w); m_issued++; end
                    else begin m_err = 1'b1; if (m_errc < 255) m_errc++; end
                end
            end
        end
    end

    // Present one request and hold it until accepted (bounded wait).
    task automatic send(input bit sel, input logic [2:0] f, input logic [6:0] o,
                        input logic [4:0] d, input logic [2:0] fn3, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [6:0] fn7, input logic [31:0] im);
        bit acc;
        acc = 1'b0;
        fmt = f; opc = o; rd = d; f3 = fn3; rs1 = s1; rs2 = s2; f7 = fn7; imm = im;
        if (sel) vb = 1'b1; else va = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = sel ? ifb.in_ready : ifa.in_ready;
            @(posedge clk); #1;
            if (rnd_rdy) ra = ($urandom % 10) < 7;
        end
        va = 1'b0; vb = 1'b0;
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_clear(input bit sel);
        @(posedge clk); #1;
        if (sel) clr_b = 1'b1; else clr_a = 1'b1;
        @(posedge clk); #1;
        clr_a = 1'b0; clr_b = 1'b0;
    endtask

    logic [31:0] bnd [12] = '{32'd2047, 32'hFFFF_F800, 32'd2048, 32'hFFFF_F7FF,
                              32'd4094, 32'hFFFF_F000, 32'd4096, 32'd1048574,
                              32'hFFF0_0000, 32'd1048576, 32'h1234_5000, 32'd1};

    initial begin
        rst_a = 1'b0; rst_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
        va = 1'b0; vb = 1'b0; ra = 1'b0; rb = 1'b0;
        fmt = 3'd0; opc = 7'd0; rd = 5'd0; f3 = 3'd0; rs1 = 5'd0; rs2 = 5'd0;
        f7 = 7'd0; imm = 32'd0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.in_ready", ifa.in_ready, 32'd0);
        @(posedge clk); #1;
        rst_a = 1'b1; rst_b = 1'b1; mon_on = 1'b1;
        @(negedge clk);
        chk("rst.wr_valid", ifa.wr_valid, 32'd0);
        chk("rst.wr_addr", ifa.wr_addr, 32'h0);
        chk("rst.wr_data", ifa.wr_data, 32'h0);
        chk("rst.b_wr_addr", ifb.wr_addr, 32'hFFFF_FFFC);
        chk("rst.b_err_count", ifb.err_count, 32'd0);
        @(posedge clk); #1;

        // ADDI x1, x0, 21
        ra = 1'b1;
        send(1'b0, 3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd21);
        chk("addi.valid", ifa.wr_valid, 32'd1);
        chk("addi.data", ifa.wr_data, 32'h0150_0093);
        chk("addi.addr", ifa.wr_addr, 32'h0);

        // AND then JAL back to back from a fresh address
        pulse_clear(1'b0);
        send(1'b0, 3'd0, 7'h33, 5'd10, 3'd7, 5'd1, 5'd2, 7'd0, 32'd0);
        chk("and.data", ifa.wr_data, 32'h0020_F533);
        chk("and.addr", ifa.wr_addr, 32'h0);
        send(1'b0, 3'd5, 7'h6F, 5'd25, 3'd0, 5'd0, 5'd0, 7'd0, 32'd4);
        chk("jal.data", ifa.wr_data, 32'h0040_0CEF);
        chk("jal.addr", ifa.wr_addr, 32'h4);

        // SW and BEQ
        send(1'b0, 3'd2, 7'h23, 5'd0, 3'd2, 5'd2, 5'd1, 7'd0, 32'd1);
        chk("sw.data", ifa.wr_data, 32'h0011_20A3);
        send(1'b0, 3'd3, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'hFFFF_FFFC);
        chk("beq.data", ifa.wr_data, 32'hFE20_8EE3);
        chk("beq.addr", ifa.wr_addr, 32'hC);

        // backpressure: BEQ stalls while another request waits
        ra = 1'b0;
        fmt = 3'd0; opc = 7'h33; rd = 5'd3; f3 = 3'd0; rs1 = 5'd4; rs2 = 5'd5; f7 = 7'h20;
        va = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp.in_ready", ifa.in_ready, 32'd0);
            chk("bp.data", ifa.wr_data, 32'hFE20_8EE3);
            chk("bp.addr", ifa.wr_addr, 32'hC);
            @(posedge clk); #1;
        end
        ra = 1'b1;
        send(1'b0, 3'd0, 7'h33, 5'd3, 3'd0, 5'd4, 5'd5, 7'h20, 32'd0);
        chk("bp.sub.data", ifa.wr_data, 32'h4052_01B3);
        chk("bp.sub.addr", ifa.wr_addr, 32'h10);

        // illegal requests are consumed without a write
        send(1'b0, 3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048);
        send(1'b0, 3'd3, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'd3);
        @(negedge clk);
        chk("ill.err", ifa.err, 32'd1);
        chk("ill.err_count", ifa.err_count, 32'd2);
        chk("ill.no_write", ifa.wr_valid, 32'd0);
        @(posedge clk); #1;
        send(1'b0, 3'd4, 7'h37, 5'd7, 3'd0, 5'd0, 5'd0, 7'd0, 32'hABCD_E000);
        chk("ill.next.data", ifa.wr_data, 32'hABCD_E3B7);
        chk("ill.next.addr", ifa.wr_addr, 32'h14);

        // randomized run until all 64 words are issued
        pulse_clear(1'b0);
        rnd_rdy = 1'b1;
        for (int k = 0; k < 600 && m_issued < 64; k++) begin
            logic [2:0]  rf;
            logic [6:0]  ro;
            logic [31:0] ri;
            if ($urandom % 6 == 0) begin
                @(posedge clk); #1;
                ra = ($urandom % 10) < 7;
            end else begin
                rf = ($urandom % 16 < 14) ? 3'($urandom % 6) : 3'(6 + $urandom % 2);
                ro = 7'($urandom);
                if ($urandom % 10 != 0) ro[1:0] = 2'b11;
                case ($urandom % 4)
                    0: ri = $urandom;
                    1: ri = 32'($urandom_range(0, 8191)) - 32'd4096;
                    2: ri = bnd[$urandom % 12];
                    default: ri = (rf == 3'd4) ? ($urandom & 32'hFFFF_F000)
                                               : ((32'($urandom_range(0, 2097151)) - 32'd1048576) & ~32'd1);
                endcase
                send(1'b0, rf, ro, 5'($urandom), 3'($urandom), 5'($urandom),
                     5'($urandom), 7'($urandom), ri);
            end
        end
        rnd_rdy = 1'b0;
        ra = 1'b1;
        for (int i = 0; i < 100 && !ifa.done; i++) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rand.done", ifa.done, 32'd1);
        chk("rand.in_ready", ifa.in_ready, 32'd0);
        chk("rand.drained", q.size(), 32'd0);
        mon_on = 1'b0;

        // instance B: error, wrap, done, clear, reset during a stall
        @(posedge clk); #1;
        rb = 1'b1;
        send(1'b1, 3'd7, 7'h13, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);
        send(1'b1, 3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd21);
        chk("b.w0.addr", ifb.wr_addr, 32'hFFFF_FFFC);
        chk("b.w0.data", ifb.wr_data, 32'h0150_0093);
        send(1'b1, 3'd0, 7'h33, 5'd10, 3'd7, 5'd1, 5'd2, 7'd0, 32'd0);
        chk("b.w1.addr", ifb.wr_addr, 32'h0);
        chk("b.w1.data", ifb.wr_data, 32'h0020_F533);
        @(posedge clk); #1;
        chk("b.done", ifb.done, 32'd1);
        chk("b.done.in_ready", ifb.in_ready, 32'd0);
        chk("b.done.wr_valid", ifb.wr_valid, 32'd0);
        pulse_clear(1'b1);
        chk("b.clr.done", ifb.done, 32'd0);
        chk("b.clr.addr", ifb.wr_addr, 32'hFFFF_FFFC);
        chk("b.clr.err", ifb.err, 32'd1);
        chk("b.clr.err_count", ifb.err_count, 32'd1);
        rb = 1'b0;
        send(1'b1, 3'd1, 7'h13, 5'd2, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5);
        chk("b.stall.valid", ifb.wr_valid, 32'd1);
        rst_b = 1'b0;
        @(posedge clk); #1;
        rst_b = 1'b1;
        chk("b.rst.wr_valid", ifb.wr_valid, 32'd0);
        chk("b.rst.err", ifb.err, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rv32i_instr_encoder.md
Name: rv32i_instr_encoder

Overview:
Instruction encoder and loader for the RV32I core. It is the write-side counterpart of the decode stage: it accepts instruction fields plus a format tag and assembles the 32-bit RV32I word, using the same field placement the decoder extracts. Each legal word is streamed to the instruction-memory write port at sequential word addresses. Testbenches and boot logic use it to fill program memory, so programs are not hard-coded into the ROM.

Parameters:
BASE_ADDR, 32'h0, byte address of the first word written
DEPTH, 64, number of words to write before the block reports done (range 1..2^30)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-low reset
clear  input  1  synchronous restart: same effect as reset on all state except err
in_valid  input  1  request valid
in_ready  output  1  request accepted when in_valid && in_ready at posedge
fmt  input  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 illegal
opcode  input  7  major opcode, passed through to bits [6:0]
rd  input  5  destination register
funct3  input  3  funct3 field
rs1  input  5  source register 1
rs2  input  5  source register 2
funct7  input  7  bits [31:25]; used for R only
imm  input  32  signed byte immediate (for U: the full upper value)
wr_valid  output  1  write request to instruction memory
wr_ready  input  1  memory accepts the write when wr_valid && wr_ready
wr_addr  output  32  byte address of the write
wr_data  output  32  encoded instruction
done  output  1  DEPTH words written
err  output  1  sticky: an illegal request was seen
err_count  output  8  number of illegal requests, saturating at 255

Behaviour:
- Reset (reset=0 at posedge):
  - wr_valid=0, wr_addr=BASE_ADDR, wr_data=0.
  - done=0, err=0, err_count=0.
  - Internal issued and written counters = 0.
  - in_ready is 0 during the reset cycle.
- Reset has priority over clear. Reset asserted mid-transfer drops any pending write.
- clear has the same effect as reset, except err and err_count are kept.
- Encoding (combinational from the inputs, registered on accept):
  - R: {funct7, rs2, rs1, funct3, rd, opcode}
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - U: {imm[31:12], rd, opcode}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
- Illegal request, if any of the following hold:
  - fmt is 6 or 7, or opcode[1:0] != 2'b11.
  - I/S: imm[31:11] is not all equal (value does not fit 12-bit signed).
  - B: imm[0]=1, or imm[31:12] is not all equal.
  - J: imm[0]=1, or imm[31:20] is not all equal.
  - U: imm[11:0] != 0.
  - R: no immediate check; fields beyond their width cannot occur.
- Illegal requests are still handshaken (consumed). They produce no write and do not advance the issued count. err is set, err_count increments (saturating).
- in_ready = reset && !clear && (issued < DEPTH) && (!wr_valid || wr_ready).
  - This gives a single-entry output register that can take a new request in the same cycle its current word drains.
- Latency: a legal request accepted at edge N gives wr_valid=1 after edge N, with wr_data equal to the encoding. issued increments at edge N.
- wr_valid, wr_addr and wr_data hold stable until wr_ready=1. A memory that never asserts wr_ready stalls the block indefinitely; there is no timeout.
- On each write handshake:
  - wr_addr advances by 4 for the next write, with 32-bit wrap-around (0xFFFFFFFC goes to 0).
  - written increments.
  - If no new word is loaded in that cycle, wr_valid falls to 0.
- Accepted back-to-back with wr_ready=1 held high, the block sustains one word per cycle.
- done goes to 1 at the edge where written reaches DEPTH, and holds until reset or clear. in_ready stays 0 once issued == DEPTH.

Test Plan:
- ADDI: fmt=1, opcode=0x13, rd=1, rs1=0, funct3=0, imm=21, wr_ready=1 -> one cycle later wr_valid=1, wr_data=0x01500093, wr_addr=BASE_ADDR.
- AND then JAL back-to-back:
  - AND: fmt=0, opcode=0x33, rd=10, rs1=1, rs2=2, funct3=7, funct7=0.
  - JAL: fmt=5, opcode=0x6F, rd=25, imm=4.
  - -> wr_data 0x0020F533 at addr 0x0, then 0x00400CEF at 0x4, on consecutive cycles.
- Store and branch:
  - SW: fmt=2, opcode=0x23, funct3=2, rs1=2, rs2=1, imm=1 -> 0x001120A3.
  - BEQ: fmt=3, opcode=0x63, rs1=1, rs2=2, imm=-4 -> 0xFE208EE3.
- Backpressure: hold wr_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, and wr_data/wr_addr stay stable. Release -> exactly one write per word, no word lost or duplicated.
- Illegal requests, fmt=1, imm=2048 and fmt=3, imm=3 -> both accepted with no write. err=1, err_count=2, and the next legal word is still written at the next sequential address.
- DEPTH=2: write 2 words -> done=1, in_ready=0. Then pulse clear -> done=0, wr_addr=BASE_ADDR, err unchanged. Assert reset during a stalled write -> wr_valid=0 on the next cycle.
